gb_hdma_ctrl: RTL
=================

# gb_hdma_ctrl

CGB-style VRAM DMA (HDMA) controller for the LR35902 system. It owns MMIO registers FF51–FF55 and copies 16-byte blocks from the cartridge/WRAM bus into VRAM, in one of two modes:
- General-purpose: the whole transfer runs in one burst.
- H-blank: one block is copied per PPU H-blank.

It sits beside the MMU address mux, drives the source bus and the VRAM write port, and stalls the CPU while it owns those buses.

## Interface
- BLOCK_BYTES, 16, bytes per block; must be a power of 2.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- cpu_addr  in  16  CPU address.
- cpu_wr  in  1  CPU write strobe.
- cpu_rd  in  1  CPU read strobe.
- cpu_wdata  in  8  CPU write data.
- cpu_rdata  out  8  read data for FF51–FF55; FF for any other address; combinational.
- ppu_mode  in  2  PPU mode; 00 is H-blank, 11 is pixel transfer.
- lcd_on  in  1  LCDC bit 7.
- src_addr  out  16  source-bus address.
- src_rd  out  1  source-bus read strobe.
- src_data  in  8  source-bus read data.
- vram_addr  out  13  VRAM write address.
- vram_wdata  out  8  VRAM write data.
- vram_wr  out  1  VRAM write strobe.
- cpu_stall  out  1  CPU must hold; MMU grants the source bus and VRAM to this block.
- busy  out  1  a transfer is armed or running.

## Operation
Registers:
- FF51/FF52 (src hi/lo): source = {FF51, FF52[7:4], 4'h0}.
- FF53/FF54 (dst hi/lo): destination = {FF53[4:0], FF54[7:4], 4'h0}.
- FF51–FF54 are shadow registers, writable at any time. They read FF.
- Shadows are copied into working pointers src_ptr (16 b) and dst_ptr (13 b) only when a FF55 write starts a transfer.
- FF55 write sets length in blocks = cpu_wdata[6:0] + 1, loaded into blk_rem = cpu_wdata[6:0].
  - Bit 7 = 0 while IDLE: start general-purpose mode.
  - Bit 7 = 1: start H-blank mode.
- FF55 read:
  - While busy: {1'b0, blk_rem}.
  - Otherwise: {1'b1, blk_rem}; this reads FF after a normal completion.

States:
- IDLE: all strobes low.
  - FF55 write with bit 7 = 0 goes to GP_XFER.
  - FF55 write with bit 7 = 1 goes to HB_XFER if lcd_on = 0 or ppu_mode = 00; otherwise to HB_WAIT.
- GP_XFER: copy blocks back-to-back until all are done, then go to IDLE.
- HB_WAIT: wait for H-blank entry, detected as ppu_mode changing from a registered value of 11 to 00. On entry, go to HB_XFER.
  - FF55 write with bit 7 = 0: terminate. Go to IDLE; blk_rem is held, so FF55 reads {1, blk_rem}.
  - FF55 write with bit 7 = 1: reload blk_rem from the new length. Pointers are kept.
- HB_XFER: copy exactly one block.
  - If it was the last block, go to IDLE.
  - Otherwise go to HB_WAIT.

Transfer pipeline:
- Byte i is read in cycle k: src_rd = 1, src_addr = src_ptr.
- src_data is registered at the end of cycle k.
- In cycle k+1: vram_wr = 1, vram_wdata = the registered byte, vram_addr = dst_ptr.
- The read of byte i+1 overlaps the write of byte i.
- src_ptr increments modulo 2^16.
- dst_ptr increments modulo 2^13; it wraps 1FFF→0000 and the transfer continues.
- blk_rem decrements after each block's last write. On the final block it wraps 00→7F, so FF55 reads FF.

Stall and busy:
- cpu_stall = 1 in GP_XFER and HB_XFER, including the pipeline-drain cycle.
- busy = 1 in every state except IDLE.

Reset:
- Returns to IDLE at any point, including mid-block.
- Shadow registers reset to FF. blk_rem resets to 7F.
- All strobes, cpu_stall and busy reset to 0.
- Address/data outputs reset to 0.

## Timing
- FF55 start write sampled at edge t (GP):
  - cpu_stall and the first src_rd in cycle t+1.
  - First vram_wr in cycle t+2.
  - For L = blocks × BLOCK_BYTES bytes: last vram_wr in cycle t+L+1; cpu_stall falls at cycle t+L+2.
- H-blank block: starts the cycle after the 11→00 edge is detected and occupies BLOCK_BYTES+1 cycles.
- ppu_mode leaving 00 mid-block does not abort the block.
- Since the CPU is stalled during XFER states, it cannot write FF55 then.
- A FF55 write coincident with H-blank detection in HB_WAIT: the write wins and the edge is ignored.

## Configuration
- HDMA_HBLANK_EN defined: H-blank mode as described.
- Not defined: FF55 bit 7 is ignored; every start is general-purpose; states HB_WAIT and HB_XFER are absent; the FF55 read value's bit 7 follows busy only.

## Test plan
- FF51=C0, FF52=00, FF53=80, FF54=00, FF55=01 → 32 vram_wr at 0000–001F with C000–C01F data; stall lasts 33 cycles; FF55 then reads FF.
- FF55=82 with ppu_mode=11 → no writes until 11→00; then 16 writes per H-blank over 3 H-blanks; FF55 reads 01, 00, then FF.
- H-blank start, then FF55=00 written after the first block → transfer stops; FF55 reads 81; no further writes on later H-blanks.
- FF53=1F, FF54=F0, FF55=01 → writes 1FF0–1FFF, then 0000–000F.
- rst asserted at byte 7 of a GP transfer → next cycle: vram_wr=0, cpu_stall=0, FF55 reads FF; no further writes.

Source files
------------

// File: rtl/gb_hdma_ctrl_if.sv
// Bus bundle for the HDMA controller: CPU MMIO port, PPU status, source-bus read port and VRAM write port.
// The master modport is the HDMA side; the slave modport is the MMU/system side.
interface gb_hdma_ctrl_if;
  logic [15:0] cpu_addr;
  logic        cpu_wr;
  logic        cpu_rd;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic [1:0]  ppu_mode;
  logic        lcd_on;
  logic [15:0] src_addr;
  logic        src_rd;
  logic [7:0]  src_data;
  logic [12:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        vram_wr;
  logic        cpu_stall;
  logic        busy;

  modport master (
    input  cpu_addr, cpu_wr, cpu_rd, cpu_wdata, ppu_mode, lcd_on, src_data,
    output cpu_rdata, src_addr, src_rd, vram_addr, vram_wdata, vram_wr, cpu_stall, busy
  );

  modport slave (
    output cpu_addr, cpu_wr, cpu_rd, cpu_wdata, ppu_mode, lcd_on, src_data,
    input  cpu_rdata, src_addr, src_rd, vram_addr, vram_wdata, vram_wr, cpu_stall, busy
  );
endinterface

// File: rtl/gb_hdma_ctrl.sv
// CGB VRAM DMA (FF51-FF55): 16-byte blocks, one byte/cycle, write lags read by one cycle; CPU stalled while copying.
// H-blank mode (HB_WAIT/HB_XFER) is built only when HDMA_HBLANK_EN is defined; otherwise every start is general-purpose.
module gb_hdma_ctrl #(
  parameter int BLOCK_BYTES = 16
) (
  input logic            clk,
  input logic            rst,
  gb_hdma_ctrl_if.master bus
);

  localparam int CW = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(BLOCK_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GP_XFER = 2'd1
`ifdef HDMA_HBLANK_EN
    ,
    S_HB_WAIT = 2'd2,
    S_HB_XFER = 2'd3
`endif
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [7:0]    r_ff51;
  logic [3:0]    r_ff52_hi;
  logic [4:0]    r_ff53_lo;
  logic [3:0]    r_ff54_hi;
  logic [15:0]   r_src_ptr;
  logic [12:0]   r_dst_ptr;
  logic [6:0]    r_blk_rem;
  logic [CW-1:0] r_byte_cnt;
  logic          r_rd_stop;
  logic          r_wr_vld;
  logic          r_wr_last;
  logic [7:0]    r_data;

  logic          w_ff55_wr;
  logic          w_start;
  logic          w_xfer;
  logic          w_one_blk;
  logic          w_rd;
  logic          w_last_rd;
  logic          w_final_rd;
  logic          w_drain_done;
  logic          w_busy;
  logic [6:0]    w_blk_rem_eff;

  assign w_ff55_wr = bus.cpu_wr && (bus.cpu_addr == 16'hFF55);
  assign w_start   = (r_state == S_IDLE) && w_ff55_wr;
  assign w_busy    = (r_state != S_IDLE);

`ifdef HDMA_HBLANK_EN
  logic [1:0] r_ppu_q;
  logic       w_hb_edge;
  logic       w_hb_reload;

  assign w_hb_edge   = (r_ppu_q == 2'b11) && (bus.ppu_mode == 2'b00);
  assign w_hb_reload = (r_state == S_HB_WAIT) && w_ff55_wr && bus.cpu_wdata[7];
  assign w_xfer      = (r_state == S_GP_XFER) || (r_state == S_HB_XFER);
  assign w_one_blk   = (r_state == S_HB_XFER);
`else
  logic w_unused_hb;
  assign w_unused_hb = ^{bus.ppu_mode, bus.lcd_on};
  assign w_xfer      = (r_state == S_GP_XFER);
  assign w_one_blk   = 1'b0;
`endif

  // Read side runs until the final byte is fetched; the write side trails by one cycle.
  assign w_rd         = w_xfer && !r_rd_stop;
  assign w_last_rd    = w_rd && (r_byte_cnt == LAST_BYTE);
  assign w_drain_done = r_rd_stop && r_wr_vld;

  // blk_rem as it will be once a block-closing write in this same cycle lands.
  assign w_blk_rem_eff = (r_wr_vld && r_wr_last) ? (r_blk_rem - 7'd1) : r_blk_rem;
  assign w_final_rd    = w_last_rd && (w_one_blk || (w_blk_rem_eff == 7'd0));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    bus.src_rd    = 1'b0;
    bus.vram_wr   = 1'b0;
    bus.cpu_stall = 1'b0;
    bus.busy      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_ff55_wr) begin
`ifdef HDMA_HBLANK_EN
          if (bus.cpu_wdata[7]) begin
            w_state_nxt = (!bus.lcd_on || (bus.ppu_mode == 2'b00)) ? S_HB_XFER : S_HB_WAIT;
          end else begin
            w_state_nxt = S_GP_XFER;
          end
`else
          w_state_nxt = S_GP_XFER;
`endif
        end
      end
      S_GP_XFER: begin
        if (w_drain_done) w_state_nxt = S_IDLE;
      end
`ifdef HDMA_HBLANK_EN
      S_HB_WAIT: begin
        // A FF55 write takes priority over a coincident H-blank edge.
        if (w_ff55_wr) begin
          if (!bus.cpu_wdata[7]) w_state_nxt = S_IDLE;
        end else if (w_hb_edge) begin
          w_state_nxt = S_HB_XFER;
        end
      end
      S_HB_XFER: begin
        if (w_drain_done) w_state_nxt = (r_blk_rem == 7'd0) ? S_IDLE : S_HB_WAIT;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase

    bus.src_rd    = w_rd;
    bus.vram_wr   = r_wr_vld;
    bus.cpu_stall = w_xfer;
    bus.busy      = w_busy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ff51     <= 8'hFF;
      r_ff52_hi  <= 4'hF;
      r_ff53_lo  <= 5'h1F;
      r_ff54_hi  <= 4'hF;
      r_src_ptr  <= 16'h0000;
      r_dst_ptr  <= 13'h0000;
      r_blk_rem  <= 7'h7F;
      r_byte_cnt <= '0;
      r_rd_stop  <= 1'b0;
      r_wr_vld   <= 1'b0;
      r_wr_last  <= 1'b0;
      r_data     <= 8'h00;
`ifdef HDMA_HBLANK_EN
      r_ppu_q    <= 2'b00;
`endif
    end else begin
      if (bus.cpu_wr) begin
        case (bus.cpu_addr)
          16'hFF51: r_ff51    <= bus.cpu_wdata;
          16'hFF52: r_ff52_hi <= bus.cpu_wdata[7:4];
          16'hFF53: r_ff53_lo <= bus.cpu_wdata[4:0];
          16'hFF54: r_ff54_hi <= bus.cpu_wdata[7:4];
          default: ;
        endcase
      end
`ifdef HDMA_HBLANK_EN
      r_ppu_q <= bus.ppu_mode;
`endif

      if (w_start) begin
        r_src_ptr  <= {r_ff51, r_ff52_hi, 4'h0};
        r_dst_ptr  <= {r_ff53_lo, r_ff54_hi, 4'h0};
        r_blk_rem  <= bus.cpu_wdata[6:0];
        r_byte_cnt <= '0;
        r_rd_stop  <= 1'b0;
        r_wr_vld   <= 1'b0;
        r_wr_last  <= 1'b0;
      end else begin
        r_wr_vld  <= w_rd;
        r_wr_last <= w_last_rd;
        if (w_rd) begin
          r_data     <= bus.src_data;
          r_src_ptr  <= r_src_ptr + 16'd1;
          r_byte_cnt <= w_last_rd ? '0 : (r_byte_cnt + CW'(1));
        end
        if (r_wr_vld) begin
          r_dst_ptr <= r_dst_ptr + 13'd1;
          if (r_wr_last) r_blk_rem <= r_blk_rem - 7'd1;
        end
        if (w_final_rd) begin
          r_rd_stop <= 1'b1;
        end else if (w_drain_done) begin
          r_rd_stop <= 1'b0;
        end
`ifdef HDMA_HBLANK_EN
        if (w_hb_reload) r_blk_rem <= bus.cpu_wdata[6:0];
`endif
      end
    end
  end

  assign bus.src_addr   = r_src_ptr;
  assign bus.vram_addr  = r_dst_ptr;
  assign bus.vram_wdata = r_data;

  // Only FF55 has readable state; bit 7 reads as "not busy".
  always_comb begin
    bus.cpu_rdata = 8'hFF;
    if (bus.cpu_rd && (bus.cpu_addr == 16'hFF55)) bus.cpu_rdata = {~w_busy, r_blk_rem};
  end

endmodule
